// File: rtl/rapid_pkg.sv
`default_nettype none
// ============================================================================
// rapid_pkg - shared RAPID pipeline types, funct3 constants and access checks
// Rev 1.0
// ============================================================================
package rapid_pkg;

    localparam int XLEN = 32;

    // funct3 encodings shared by execute and memory stages
    localparam logic [2:0] LB_or_SB = 3'b000;
    localparam logic [2:0] LH_or_SH = 3'b001;
    localparam logic [2:0] LW_or_SW = 3'b010;
    localparam logic [2:0] LBU      = 3'b100;
    localparam logic [2:0] LHU      = 3'b101;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } MEM_state_t;

    typedef struct packed {
        logic       reg_write;
        logic [4:0] rd;
        logic       mem;
        logic       iop;
        logic [3:0] fcs_opcode;
    } control_s;

    function automatic control_s control_s_default();
        return '0;
    endfunction

    function automatic logic fcs_illegal(input logic iop, input logic [2:0] f3);
        logic bad;
        if (iop) begin
            bad = (f3 > LW_or_SW);
        end else begin
            bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return bad;
    endfunction

    // Halfword needs an even address, word needs a 4-byte aligned address
    function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_align.sv
`default_nettype none
// ============================================================================
// mem_lane_align - store byte-enable/data encoding and load lane extraction
// Rev 1.0
// ============================================================================
module mem_lane_align
    import rapid_pkg::*;
(
    input  logic            i_is_store,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = '0;
        if (i_is_store) begin
            case (i_funct3)
                LB_or_SB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_store_data[7:0]}};
                end
                LH_or_SH: begin
                    o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_store_data[15:0]}};
                end
                LW_or_SW: begin
                    o_be    = 4'b1111;
                    o_wdata = i_store_data;
                end
                default: begin
                    o_be    = 4'b0000;
                    o_wdata = '0;
                end
            endcase
        end
    end

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            LB_or_SB: o_load_data = {{24{w_byte[7]}}, w_byte};
            LH_or_SH: o_load_data = {{16{w_half[15]}}, w_half};
            LW_or_SW: o_load_data = i_rdata;
            LBU:      o_load_data = {24'h0, w_byte};
            LHU:      o_load_data = {16'h0, w_half};
            default:  o_load_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// mem_access_stage - RAPID memory stage: data-memory load/store over req/ack
// Rev 1.0
// ============================================================================
module mem_access_stage
    import rapid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    input  control_s        i_control_signal,
    input  logic [XLEN-1:0] i_rd_output,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_ready,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    input  logic            i_wb_ready,
    output logic            o_done,
    output control_s        o_control_signal,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_misaligned,
    output logic            o_fault,
    output MEM_state_t      o_current_state
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    MEM_state_t         r_state;
    MEM_state_t         w_next_state;
    control_s           r_ctrl;
    logic [XLEN-1:0]    r_addr;
    logic [XLEN-1:0]    r_store_data;
    logic [XLEN-1:0]    r_wb_data;
    logic               r_misaligned;
    logic               r_fault;
    logic [c_CNT_W-1:0] r_count;

    logic               w_accept;
    logic               w_in_illegal;
    logic               w_in_misaligned;
    logic               w_access;
    logic               w_timeout;
    logic [3:0]         w_be;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_load_data;

    assign w_accept        = (r_state == MEM_IDLE) && i_valid;
    assign w_in_illegal    = i_control_signal.mem
                           && fcs_illegal(i_control_signal.iop, i_control_signal.fcs_opcode[2:0]);
    assign w_in_misaligned = i_control_signal.mem && !w_in_illegal
                           && access_misaligned(i_control_signal.fcs_opcode[2:0], i_rd_output[1:0]);
    assign w_access        = (r_state == MEM_ACCESS);
    assign w_timeout       = w_access && !i_dmem_ack && (r_count == c_CNT_LAST);

    mem_lane_align u_align (
        .i_is_store   (r_ctrl.iop),
        .i_funct3     (r_ctrl.fcs_opcode[2:0]),
        .i_addr_lo    (r_addr[1:0]),
        .i_store_data (r_store_data),
        .i_rdata      (i_dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MEM_IDLE: begin
                if (i_valid) begin
                    w_next_state = (i_control_signal.mem && !w_in_illegal && !w_in_misaligned)
                                 ? MEM_ACCESS : MEM_DONE;
                end
            end
            MEM_ACCESS: begin
                if (i_dmem_ack || w_timeout) begin
                    w_next_state = MEM_DONE;
                end
            end
            MEM_DONE: begin
                if (i_wb_ready) begin
                    w_next_state = MEM_IDLE;
                end
            end
            default: w_next_state = MEM_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ctrl       <= control_s_default();
            r_addr       <= '0;
            r_store_data <= '0;
            r_wb_data    <= '0;
            r_misaligned <= 1'b0;
            r_fault      <= 1'b0;
            r_count      <= '0;
        end else if (w_accept) begin
            r_ctrl       <= i_control_signal;
            r_addr       <= i_rd_output;
            r_store_data <= i_store_data;
            r_wb_data    <= i_control_signal.mem ? '0 : i_rd_output;
            r_misaligned <= w_in_misaligned;
            r_fault      <= w_in_illegal;
            r_count      <= '0;
        end else if (w_access) begin
            if (i_dmem_ack) begin
                r_wb_data <= r_ctrl.iop ? '0 : w_load_data;
            end else if (w_timeout) begin
                r_fault <= 1'b1;
            end else begin
                r_count <= r_count + c_CNT_W'(1);
            end
        end
    end

    // Bus signals are driven from latched state only while the request is up
    assign o_dmem_req       = w_access;
    assign o_dmem_we        = w_access && r_ctrl.iop;
    assign o_dmem_addr      = w_access ? {r_addr[XLEN-1:2], 2'b00} : '0;
    assign o_dmem_be        = w_access ? w_be : 4'b0000;
    assign o_dmem_wdata     = w_access ? w_wdata : '0;

    assign o_ready          = (r_state == MEM_IDLE);
    assign o_done           = (r_state == MEM_DONE);
    assign o_control_signal = r_ctrl;
    assign o_wb_data        = r_wb_data;
    assign o_misaligned     = r_misaligned;
    assign o_fault          = r_fault;
    assign o_current_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_access_stage - scoreboard bench for the RAPID memory stage
// Rev 1.0
// ============================================================================
module tb_mem_access_stage;
    import rapid_pkg::*;

    logic        i_clk;
    logic        i_reset;
    logic        i_valid;
    control_s    i_control_signal;
    logic [31:0] i_rd_output;
    logic [31:0] i_store_data;
    logic        o_ready;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        i_wb_ready;
    logic        o_done;
    control_s    o_control_signal;
    logic [31:0] o_wb_data;
    logic        o_misaligned;
    logic        o_fault;
    MEM_state_t  o_current_state;

    typedef struct {
        logic [31:0] data;
        logic        mis;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   req_cycles = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_valid          (i_valid),
        .i_control_signal (i_control_signal),
        .i_rd_output      (i_rd_output),
        .i_store_data     (i_store_data),
        .o_ready          (o_ready),
        .o_dmem_req       (o_dmem_req),
        .o_dmem_we        (o_dmem_we),
        .o_dmem_addr      (o_dmem_addr),
        .o_dmem_be        (o_dmem_be),
        .o_dmem_wdata     (o_dmem_wdata),
        .i_dmem_ack       (i_dmem_ack),
        .i_dmem_rdata     (i_dmem_rdata),
        .i_wb_ready       (i_wb_ready),
        .o_done           (o_done),
        .o_control_signal (o_control_signal),
        .o_wb_data        (o_wb_data),
        .o_misaligned     (o_misaligned),
        .o_fault          (o_fault),
        .o_current_state  (o_current_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (o_dmem_req === 1'b1) req_cycles++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic control_s mk_ctrl(input logic mem, input logic iop, input logic [2:0] f3);
        control_s c;
        c            = control_s_default();
        c.mem        = mem;
        c.iop        = iop;
        c.fcs_opcode = {1'b0, f3};
        c.rd         = 5'd7;
        c.reg_write  = !iop;
        return c;
    endfunction

    task automatic send(input control_s c, input logic [31:0] addr, input logic [31:0] sd);
        i_valid          = 1'b1;
        i_control_signal = c;
        i_rd_output      = addr;
        i_store_data     = sd;
        @(negedge i_clk);
        i_valid          = 1'b0;
    endtask

    task automatic wait_done(input int lim, output bit ok);
        int n = 0;
        while (o_done !== 1'b1 && n < lim) begin
            @(negedge i_clk);
            n++;
        end
        ok = (o_done === 1'b1);
    endtask

    task automatic release_wb();
        i_wb_ready = 1'b1;
        @(negedge i_clk);
        i_wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (o_current_state !== MEM_IDLE || o_ready !== 1'b1)
            $display("FAIL reset_state: state=%0d ready=%b, want 0 1", o_current_state, o_ready);
        else n_pass++;
        n_checks++;
        if ({o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata} !== 71'h0)
            $display("FAIL reset_bus: req=%b we=%b be=%h addr=%h wdata=%h, want all 0",
                     o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata);
        else n_pass++;
        n_checks++;
        if ({o_done, o_wb_data, o_misaligned, o_fault} !== 35'h0 || o_control_signal !== control_s_default())
            $display("FAIL reset_outputs: done=%b wb=%h mis=%b flt=%b ctrl=%h, want 0 0 0 0 0",
                     o_done, o_wb_data, o_misaligned, o_fault, o_control_signal);
        else n_pass++;
        i_reset = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_store_word();
        exp_t e;
        bit   ok;
        sb.push_back('{32'h0, 1'b0, 1'b0});
        send(mk_ctrl(1'b1, 1'b1, LW_or_SW), 32'h100, 32'hDEADBEEF);
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if (o_dmem_req !== 1'b1 || o_dmem_we !== 1'b1 || o_dmem_be !== 4'hF
                || o_dmem_wdata !== 32'hDEADBEEF || o_dmem_addr !== 32'h100)
                $display("FAIL sw_bus cycle %0d: req=%b we=%b be=%h wdata=%h addr=%h, want 1 1 f deadbeef 00000100",
                         k, o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_wdata, o_dmem_addr);
            else n_pass++;
            if (k == 3) i_dmem_ack = 1'b1;
            @(negedge i_clk);
        end
        i_dmem_ack = 1'b0;
        n_checks++;
        if (o_done !== 1'b1 || o_dmem_req !== 1'b0)
            $display("FAIL sw_done_latency: done=%b req=%b one cycle after ack, want 1 0", o_done, o_dmem_req);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ({o_wb_data, o_misaligned, o_fault} !== {e.data, e.mis, e.flt})
            $display("FAIL sw_result: wb=%h mis=%b flt=%b, want %h %b %b",
                     o_wb_data, o_misaligned, o_fault, e.data, e.mis, e.flt);
        else n_pass++;
        @(negedge i_clk);
        n_checks++;
        if (o_done !== 1'b1 || o_ready !== 1'b0)
            $display("FAIL sw_done_hold: done=%b ready=%b without wb_ready, want 1 0", o_done, o_ready);
        else n_pass++;
        release_wb();
        ok = (o_ready === 1'b1 && o_done === 1'b0);
        n_checks++;
        if (!ok) $display("FAIL sw_release: ready=%b done=%b, want 1 0", o_ready, o_done);
        else n_pass++;
    endtask

    task automatic test_load_byte();
        exp_t e;
        bit   ok;
        for (int s = 0; s < 2; s++) begin
            sb.push_back('{(s == 0) ? 32'hFFFFFF80 : 32'h00000080, 1'b0, 1'b0});
            send(mk_ctrl(1'b1, 1'b0, (s == 0) ? LB_or_SB : LBU), 32'h103, 32'h0);
            n_checks++;
            if (o_dmem_req !== 1'b1 || o_dmem_we !== 1'b0 || o_dmem_be !== 4'h0 || o_dmem_addr !== 32'h100)
                $display("FAIL lb_bus[%0d]: req=%b we=%b be=%h addr=%h, want 1 0 0 00000100",
                         s, o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr);
            else n_pass++;
            i_dmem_rdata = 32'h80FFFF7F;
            i_dmem_ack   = 1'b1;
            @(negedge i_clk);
            i_dmem_ack   = 1'b0;
            i_dmem_rdata = 32'h0;
            wait_done(4, ok);
            n_checks++;
            if (!ok) $display("FAIL lb_done[%0d]: done=%b, want 1", s, o_done);
            else n_pass++;
            e = sb.pop_front();
            n_checks++;
            if ({o_wb_data, o_misaligned, o_fault} !== {e.data, e.mis, e.flt})
                $display("FAIL lb_result[%0d]: wb=%h mis=%b flt=%b, want %h %b %b",
                         s, o_wb_data, o_misaligned, o_fault, e.data, e.mis, e.flt);
            else n_pass++;
            release_wb();
        end
    endtask

    task automatic test_half_and_bad();
        exp_t e;
        bit   ok;
        int   r0;
        sb.push_back('{32'h0, 1'b0, 1'b0});
        send(mk_ctrl(1'b1, 1'b1, LH_or_SH), 32'h202, 32'h1234ABCD);
        n_checks++;
        if (o_dmem_be !== 4'b1100 || o_dmem_wdata !== 32'hABCDABCD || o_dmem_addr !== 32'h200)
            $display("FAIL sh_bus: be=%b wdata=%h addr=%h, want 1100 abcdabcd 00000200",
                     o_dmem_be, o_dmem_wdata, o_dmem_addr);
        else n_pass++;
        i_dmem_ack = 1'b1;
        @(negedge i_clk);
        i_dmem_ack = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (o_done !== 1'b1 || {o_wb_data, o_misaligned, o_fault} !== {e.data, e.mis, e.flt})
            $display("FAIL sh_result: done=%b wb=%h mis=%b flt=%b, want 1 %h %b %b",
                     o_done, o_wb_data, o_misaligned, o_fault, e.data, e.mis, e.flt);
        else n_pass++;
        release_wb();
        // misaligned halfword load, then an illegal load funct3
        for (int t = 0; t < 2; t++) begin
            sb.push_back('{32'h0, (t == 0), (t == 1)});
            r0 = req_cycles;
            send(mk_ctrl(1'b1, 1'b0, (t == 0) ? LH_or_SH : 3'b011), (t == 0) ? 32'h201 : 32'h100, 32'h0);
            n_checks++;
            if (o_done !== 1'b1 || o_current_state !== MEM_DONE)
                $display("FAIL bad_done[%0d]: done=%b state=%0d, want 1 2", t, o_done, o_current_state);
            else n_pass++;
            e = sb.pop_front();
            n_checks++;
            if ({o_wb_data, o_misaligned, o_fault} !== {e.data, e.mis, e.flt})
                $display("FAIL bad_result[%0d]: wb=%h mis=%b flt=%b, want %h %b %b",
                         t, o_wb_data, o_misaligned, o_fault, e.data, e.mis, e.flt);
            else n_pass++;
            release_wb();
            n_checks++;
            if (req_cycles !== r0)
                $display("FAIL bad_noreq[%0d]: req cycles=%0d, want 0", t, req_cycles - r0);
            else n_pass++;
        end
    endtask

    task automatic test_passthrough();
        exp_t e;
        sb.push_back('{32'h55, 1'b0, 1'b0});
        send(mk_ctrl(1'b0, 1'b0, 3'b000), 32'h55, 32'hFFFF_FFFF);
        e = sb.pop_front();
        n_checks++;
        if (o_done !== 1'b1 || o_dmem_req !== 1'b0
            || {o_wb_data, o_misaligned, o_fault} !== {e.data, e.mis, e.flt})
            $display("FAIL alu_pass: done=%b req=%b wb=%h mis=%b flt=%b, want 1 0 %h %b %b",
                     o_done, o_dmem_req, o_wb_data, o_misaligned, o_fault, e.data, e.mis, e.flt);
        else n_pass++;
        n_checks++;
        if (o_control_signal !== mk_ctrl(1'b0, 1'b0, 3'b000))
            $display("FAIL alu_ctrl: ctrl=%h, want %h", o_control_signal, mk_ctrl(1'b0, 1'b0, 3'b000));
        else n_pass++;
        release_wb();
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   ok;
        int   r0;
        sb.push_back('{32'h0, 1'b0, 1'b1});
        r0 = req_cycles;
        send(mk_ctrl(1'b1, 1'b0, LW_or_SW), 32'h300, 32'h0);
        wait_done(40, ok);
        n_checks++;
        if (!ok || o_dmem_req !== 1'b0 || req_cycles - r0 != 16)
            $display("FAIL timeout_req: done=%b req=%b req cycles=%0d, want 1 0 16",
                     o_done, o_dmem_req, req_cycles - r0);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if ({o_wb_data, o_misaligned, o_fault} !== {e.data, e.mis, e.flt})
            $display("FAIL timeout_result: wb=%h mis=%b flt=%b, want %h %b %b",
                     o_wb_data, o_misaligned, o_fault, e.data, e.mis, e.flt);
        else n_pass++;
        release_wb();
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h1234_5678;
        @(negedge i_clk);
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'h0;
        n_checks++;
        if (o_current_state !== MEM_IDLE || o_done !== 1'b0 || o_wb_data !== 32'h0)
            $display("FAIL late_ack: state=%0d done=%b wb=%h, want 0 0 00000000",
                     o_current_state, o_done, o_wb_data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        exp_t e;
        bit   ok;
        send(mk_ctrl(1'b1, 1'b1, LW_or_SW), 32'h400, 32'h1);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        n_checks++;
        if (o_dmem_req !== 1'b0 || o_current_state !== MEM_IDLE || o_control_signal !== control_s_default())
            $display("FAIL reset_mid: req=%b state=%0d ctrl=%h, want 0 0 0",
                     o_dmem_req, o_current_state, o_control_signal);
        else n_pass++;
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        sb.push_back('{32'h0000BEEF, 1'b0, 1'b0});
        send(mk_ctrl(1'b1, 1'b0, LHU), 32'h402, 32'h0);
        i_dmem_rdata = 32'hBEEF1234;
        i_dmem_ack   = 1'b1;
        @(negedge i_clk);
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'h0;
        wait_done(4, ok);
        e = sb.pop_front();
        n_checks++;
        if (!ok || {o_wb_data, o_misaligned, o_fault} !== {e.data, e.mis, e.flt})
            $display("FAIL post_reset_lhu: done=%b wb=%h mis=%b flt=%b, want 1 %h %b %b",
                     o_done, o_wb_data, o_misaligned, o_fault, e.data, e.mis, e.flt);
        else n_pass++;
        release_wb();
    endtask

    initial begin
        i_reset          = 1'b1;
        i_valid          = 1'b0;
        i_control_signal = control_s_default();
        i_rd_output      = 32'h0;
        i_store_data     = 32'h0;
        i_dmem_ack       = 1'b0;
        i_dmem_rdata     = 32'h0;
        i_wb_ready       = 1'b0;

        test_reset();
        test_store_word();
        test_load_byte();
        test_half_and_bad();
        test_passthrough();
        test_timeout();
        test_reset_mid_access();

        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
